// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO burst reader: state encoding and occupancy-count width.
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

  // Occupancy needs one bit more than the address so a full FIFO reads as 2**ADDR_WIDTH.
  function automatic int unsigned cnt_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/fifo_rd_timeout_ctr.sv
// Idle counter for the FIFO reader: counts while partial data sits unread and
// pulses expire on the cycle the count reaches TIMEOUT_CYCLES-1.
module fifo_rd_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic expire
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Dropping run (empty FIFO or leaving IDLE) clears the count.
  always_comb begin
    expire = run && (cnt_q == LAST);
    cnt_d  = (run && !expire) ? cnt_q + 1'b1 : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Pops fixed-length bursts from a FWFT FIFO onto a valid/ready stream with m_last.
// Define FIFO_READER_TIMEOUT_EN to flush partial contents after TIMEOUT_CYCLES idle cycles.
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned BURST_LEN      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  input  logic                  fifo_full,
  input  logic [ADDR_WIDTH-1:0] fifo_depth,
  output logic                  fifo_ren,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  burst_done
);

  localparam int unsigned CNT_W = cnt_width(ADDR_WIDTH);
  localparam logic [CNT_W-1:0] BURST_LEN_C = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  rd_state_e             state_q, state_d;
  logic [CNT_W-1:0]      remaining_q, remaining_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  m_valid_q, m_valid_d;
  logic                  m_last_q, m_last_d;
  logic                  burst_done_q, burst_done_d;

  logic [CNT_W-1:0] count;
  logic             out_free, accept, partial, tmo_expire;

  assign count    = {fifo_full, fifo_depth};
  assign out_free = !m_valid_q || m_ready;
  assign accept   = m_valid_q && m_ready;
  assign partial  = (state_q == IDLE) && (count != '0) && (count < BURST_LEN_C);

`ifdef FIFO_READER_TIMEOUT_EN
  fifo_rd_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .run    (partial),
    .expire (tmo_expire)
  );
`else
  logic unused_timeout;
  assign unused_timeout = partial ^ (TIMEOUT_CYCLES != 0);
  assign tmo_expire     = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    m_data_d     = m_data_q;
    m_valid_d    = m_valid_q;
    m_last_d     = m_last_q;
    burst_done_d = 1'b0;
    fifo_ren     = 1'b0;
    case (state_q)
      IDLE: begin
        if (count >= BURST_LEN_C) begin
          state_d     = BURST;
          remaining_d = BURST_LEN_C;
        end else if (tmo_expire) begin
          state_d     = BURST;
          remaining_d = count;
        end
      end
      BURST: begin
        // A held output word blocks the pop, so m_data never changes under backpressure.
        fifo_ren = (remaining_q != '0) && !fifo_empty && out_free;
        if (fifo_ren) begin
          m_data_d    = fifo_data;
          m_valid_d   = 1'b1;
          m_last_d    = (remaining_q == ONE_C);
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == ONE_C) state_d = DRAIN;
        end else if (accept) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
        end
      end
      DRAIN: begin
        if (accept) begin
          burst_done_d = 1'b1;
          m_valid_d    = 1'b0;
          m_last_d     = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      burst_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      m_data_q     <= m_data_d;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
      burst_done_q <= burst_done_d;
    end
  end

  assign m_data     = m_data_q;
  assign m_valid    = m_valid_q;
  assign m_last     = m_last_q;
  assign busy       = (state_q != IDLE);
  assign burst_done = burst_done_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: behavioural FIFO + word scoreboard, directed corner
// sequences, a table of burst-count vectors and a randomized run.
module tb_fifo_burst_reader;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int BL = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] fifo_data, m_data;
  logic          fifo_empty, fifo_full, fifo_ren;
  logic [AW-1:0] fifo_depth;
  logic          m_valid, m_last, m_ready, busy, burst_done;

  // behavioural FIFO, independent of the DUT reset
  logic [DW-1:0] mem [16];
  logic [3:0]    rdp, wrp;
  logic [4:0]    fcnt;
  logic          wr_en, fifo_clr, pop_w, push_w;
  logic [DW-1:0] wr_data;

  assign fifo_data  = mem[rdp];
  assign fifo_empty = (fcnt == 5'd0);
  assign fifo_full  = fcnt[4];
  assign fifo_depth = fcnt[3:0];

  always #5 clk = ~clk;

  fifo_burst_reader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .fifo_depth(fifo_depth), .fifo_ren(fifo_ren),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .busy(busy), .burst_done(burst_done)
  );

  int            errs, checks, cyc_n;
  logic [DW-1:0] exp_q [$];     // written to FIFO but not yet accepted downstream
  int            acc_cyc [$];
  int            done_cnt, acc_n, exp_len, pos, lost;
  bit            last_chk, rec_acc;
  bit            prv_rst, prv_hold, prv_last_acc, acc_now, h_last;
  logic [DW-1:0] h_data;
  int            d0, a0, c0, ren_c, eb, el;
  bit            seen, found;

  typedef struct {
    int nw;     // words written
    bit pre;    // written while the reader is held in reset
    bit rnd;    // random m_ready
    int exp_b;  // bursts expected (no timeout)
    int exp_l;  // words left in FIFO (no timeout)
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fifo_proc();
    forever begin
      @(posedge clk);
      cyc_n++;
      if (fifo_clr) begin
        rdp <= '0; wrp <= '0; fcnt <= '0;
        exp_q.delete();
      end else begin
        pop_w  = fifo_ren && (fcnt != 5'd0);
        push_w = wr_en && (fcnt != 5'd16);
        if (pop_w) rdp <= rdp + 4'd1;
        if (push_w) begin
          mem[wrp] <= wr_data;
          wrp      <= wrp + 4'd1;
          exp_q.push_back(wr_data);
        end
        fcnt <= fcnt + 5'(push_w) - 5'(pop_w);
      end
    end
  endtask

  // Checks the stream contract every cycle, mid-cycle.
  task automatic mon_proc();
    forever begin
      @(negedge clk);
      if (reset) begin
        if (!prv_rst) begin
          lost = exp_q.size() - int'(fcnt);
          repeat (lost) void'(exp_q.pop_front());
        end
        prv_rst = 1; prv_hold = 0; prv_last_acc = 0; pos = 0;
      end else begin
        prv_rst = 0;
        chk("burst_done_pulse", burst_done, prv_last_acc);
        if (burst_done) done_cnt++;
        if (prv_hold) begin
          chk("hold_valid", m_valid, 1);
          chk("hold_data", m_data, h_data);
          chk("hold_last", m_last, h_last);
        end
        if (m_valid && !m_ready) chk("ren_under_hold", fifo_ren, 0);
        acc_now = m_valid && m_ready;
        if (acc_now) begin
          acc_n++;
          if (rec_acc) acc_cyc.push_back(cyc_n);
          if (exp_q.size() == 0) chk("spurious_word", m_valid, 0);
          else chk("word_order", m_data, exp_q.pop_front());
          pos++;
          if (last_chk) chk("last_position", m_last, pos == exp_len);
          if (last_chk ? (pos == exp_len) : m_last) pos = 0;
        end
        prv_last_acc = acc_now && m_last;
        prv_hold     = m_valid && !m_ready;
        h_data       = m_data;
        h_last       = m_last;
      end
    end
  endtask

  initial begin
    reset = 1; fifo_clr = 1; wr_en = 0; wr_data = '0; m_ready = 1;
    last_chk = 1; exp_len = BL; rec_acc = 0;
    errs = 0; checks = 0; cyc_n = 0; done_cnt = 0; acc_n = 0; pos = 0;
    prv_rst = 0; prv_hold = 0; prv_last_acc = 0;
    tbl[0] = '{1,  0, 0, 0, 1};
    tbl[1] = '{3,  0, 1, 0, 3};
    tbl[2] = '{4,  0, 0, 1, 0};
    tbl[3] = '{7,  0, 1, 1, 3};
    tbl[4] = '{8,  1, 0, 2, 0};
    tbl[5] = '{16, 1, 0, 4, 0};
    tbl[6] = '{16, 1, 1, 4, 0};
    tbl[7] = '{13, 0, 1, 3, 1};
    tbl[8] = '{5,  1, 1, 1, 1};
    fork
      fifo_proc();
      mon_proc();
      begin
        // reset state
        tick(); tick();
        fifo_clr = 0;
        chk("rst_valid", m_valid, 0);
        chk("rst_last", m_last, 0);
        chk("rst_data", m_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", burst_done, 0);
        chk("rst_ren", fifo_ren, 0);
        reset = 0;

`ifndef FIFO_READER_TIMEOUT_EN
        // partial data waits forever; the fourth word starts the burst
        wr_en = 1; wr_data = 16'hA001; tick();
        wr_data = 16'hA002; tick();
        wr_data = 16'hA003; tick();
        wr_en = 0;
        seen = 0;
        repeat (200) begin
          @(negedge clk);
          if (fifo_ren || m_valid || busy) seen = 1;
          tick();
        end
        chk("partial_idle", seen, 0);
        d0 = done_cnt;
        wr_en = 1; wr_data = 16'hA004; tick();
        wr_en = 0;
        @(negedge clk);
        chk("lat_t_ren", fifo_ren, 0);
        chk("lat_t_busy", busy, 0);
        tick();
        @(negedge clk);
        chk("lat_t1_ren", fifo_ren, 1);
        chk("lat_t1_valid", m_valid, 0);
        tick();
        @(negedge clk);
        chk("lat_t2_valid", m_valid, 1);
        chk("lat_t2_data", m_data, 16'hA001);
        repeat (20) tick();
        chk("burst1_done_cnt", done_cnt - d0, 1);
        chk("burst1_fifo_empty", fcnt, 0);
`endif

        // backpressure mid-burst
        d0 = done_cnt;
        wr_en = 1;
        for (int i = 0; i < 4; i++) begin
          wr_data = 16'hC000 + 16'(i);
          tick();
        end
        wr_en = 0;
        found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
          @(negedge clk);
          if (m_valid) found = 1;
          tick();
        end
        chk("stall_first_valid_seen", found, 1);
        m_ready = 0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("stall_valid", m_valid, 1);
          chk("stall_data", m_data, 16'hC001);
          chk("stall_ren", fifo_ren, 0);
          tick();
        end
        m_ready = 1;
        repeat (12) tick();
        chk("stall_done_cnt", done_cnt - d0, 1);
        chk("stall_all_delivered", exp_q.size(), 0);

        // reset after two of four words accepted
        wr_en = 1;
        for (int i = 0; i < 4; i++) begin
          wr_data = 16'hD000 + 16'(i);
          tick();
        end
        wr_en = 0;
        a0 = acc_n;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
          tick();
          if (acc_n - a0 >= 2) found = 1;
        end
        chk("rstmid_two_accepted", found, 1);
        reset = 1;
        #1;
        chk("rstmid_valid", m_valid, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_ren", fifo_ren, 0);
        chk("rstmid_fifo_cnt", fcnt, 1);
        chk("rstmid_fifo_head", fifo_data, 16'hD003);
        tick();
        chk("rstmid_model_left", exp_q.size(), 1);
        fifo_clr = 1; tick(); fifo_clr = 0;
        reset = 0;

`ifdef FIFO_READER_TIMEOUT_EN
        // short burst after the idle timeout
        d0 = done_cnt; exp_len = 2;
        c0 = cyc_n;
        wr_en = 1; wr_data = 16'hB001; tick();
        wr_data = 16'hB002; tick();
        wr_en = 0;
        found = 0; ren_c = 0;
        for (int i = 0; i < 30 && !found; i++) begin
          @(negedge clk);
          if (fifo_ren) begin found = 1; ren_c = cyc_n; end
          tick();
        end
        chk("tmo_ren_seen", found, 1);
        chk("tmo_ren_delay", ren_c - c0, 9);
        repeat (8) tick();
        chk("tmo_done_cnt", done_cnt - d0, 1);
        chk("tmo_fifo_empty", fcnt, 0);
        exp_len = BL;
`endif

        // streaming: 1 word/cycle inside a burst, 2 idle cycles between bursts
        acc_cyc.delete(); rec_acc = 1;
        wr_en = 1;
        for (int i = 0; i < 24; i++) begin
          wr_data = 16'hE000 + 16'(i);
          tick();
        end
        wr_en = 0;
        repeat (30) tick();
        rec_acc = 0;
        chk("stream_words", acc_cyc.size(), 24);
        for (int i = 1; i < acc_cyc.size(); i++)
          chk($sformatf("stream_gap%0d", i), acc_cyc[i] - acc_cyc[i-1], (i % BL == 0) ? 3 : 1);

`ifdef FIFO_READER_TIMEOUT_EN
        last_chk = 0;
`endif
        // burst-count vectors
        foreach (tbl[i]) begin
          reset = 1; fifo_clr = 1; wr_en = 0; tick(); fifo_clr = 0;
          if (!tbl[i].pre) reset = 0;
          d0 = done_cnt;
          for (int w = 0; w < tbl[i].nw; w++) begin
            wr_en = 1; wr_data = 16'(16'h100 * i + w);
            m_ready = tbl[i].rnd ? 1'($urandom % 2) : 1'b1;
            tick();
          end
          wr_en = 0; reset = 0;
          repeat (120) begin
            m_ready = tbl[i].rnd ? 1'($urandom % 2) : 1'b1;
            tick();
          end
          m_ready = 1;
          repeat (10) tick();
`ifdef FIFO_READER_TIMEOUT_EN
          eb = tbl[i].exp_b + ((tbl[i].exp_l != 0) ? 1 : 0); el = 0;
`else
          eb = tbl[i].exp_b; el = tbl[i].exp_l;
`endif
          chk($sformatf("vec%0d_bursts", i), done_cnt - d0, eb);
          chk($sformatf("vec%0d_left", i), fcnt, el);
          chk($sformatf("vec%0d_model_left", i), exp_q.size(), el);
          chk($sformatf("vec%0d_busy", i), busy, 0);
        end

        // randomized traffic against the scoreboard
        reset = 1; fifo_clr = 1; tick(); fifo_clr = 0; reset = 0;
        repeat (1500) begin
          wr_en   = ($urandom % 3 == 0);
          wr_data = 16'($urandom);
          m_ready = ($urandom % 4 != 0);
          tick();
        end
        wr_en = 0; m_ready = 1;
        repeat (60) tick();
        chk("rand_busy", busy, 0);
        chk("rand_left_model", fcnt, exp_q.size());
`ifdef FIFO_READER_TIMEOUT_EN
        chk("rand_left", fcnt, 0);
`else
        chk("rand_left_below_burst", fcnt < 5'(BL), 1);
`endif
      end
    join_any
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
